// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter for a single memory port (IDLE/ISSUE/WAIT).
// Optional WAIT-state timeout abort enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
   parameter int ADDR_WIDTH     = 4,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [1:0]              req,
   input  logic [1:0]              req_wr,
   input  logic [2*ADDR_WIDTH-1:0] req_addr,
   input  logic [2*DATA_WIDTH-1:0] req_wdata,
   output logic [1:0]              ack,
   output logic [1:0]              err,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic                    mem_wr,
   output logic                    mem_rd,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   input  logic [DATA_WIDTH-1:0]   mem_rdata,
   input  logic                    slv_rsp
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   state_t                  state;
   logic                    gnt;
   logic                    pri;
   logic                    cmd_wr;
   logic                    sel;
   logic                    sel_wr;
   logic [ADDR_WIDTH-1:0]   sel_addr;
   logic [DATA_WIDTH-1:0]   sel_wdata;

   // With both requests pending, pri names the requester not granted last.
   always_comb begin
      sel       = (req == 2'b11) ? pri : req[1];
      sel_wr    = sel ? req_wr[1] : req_wr[0];
      sel_addr  = sel ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
      sel_wdata = sel ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
   end

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         gnt       <= 1'b0;
         pri       <= 1'b0;
         cmd_wr    <= 1'b0;
         cnt       <= '0;
         ack       <= '0;
         err       <= '0;
         mem_wr    <= 1'b0;
         mem_rd    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rsp_rdata <= '0;
      end else begin
         ack    <= '0;
         err    <= '0;
         mem_wr <= 1'b0;
         mem_rd <= 1'b0;
         case (state)
            IDLE: begin
               // No arbitration during the ack cycle: the finished requester still holds req.
               if (ack == 2'b00 && req != 2'b00) begin
                  gnt       <= sel;
                  pri       <= ~sel;
                  cmd_wr    <= sel_wr;
                  mem_addr  <= sel_addr;
                  mem_wdata <= sel_wdata;
                  mem_wr    <= sel_wr;
                  mem_rd    <= ~sel_wr;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               cnt   <= '0;
               state <= WAIT;
            end
            WAIT: begin
               if (slv_rsp) begin
                  ack       <= gnt ? 2'b10 : 2'b01;
                  rsp_rdata <= cmd_wr ? '0 : mem_rdata;
                  state     <= IDLE;
               end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                  ack       <= gnt ? 2'b10 : 2'b01;
                  err       <= gnt ? 2'b10 : 2'b01;
                  rsp_rdata <= '0;
                  state     <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
`else
   assign err = '0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         gnt       <= 1'b0;
         pri       <= 1'b0;
         cmd_wr    <= 1'b0;
         ack       <= '0;
         mem_wr    <= 1'b0;
         mem_rd    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rsp_rdata <= '0;
      end else begin
         ack    <= '0;
         mem_wr <= 1'b0;
         mem_rd <= 1'b0;
         case (state)
            IDLE: begin
               // No arbitration during the ack cycle: the finished requester still holds req.
               if (ack == 2'b00 && req != 2'b00) begin
                  gnt       <= sel;
                  pri       <= ~sel;
                  cmd_wr    <= sel_wr;
                  mem_addr  <= sel_addr;
                  mem_wdata <= sel_wdata;
                  mem_wr    <= sel_wr;
                  mem_rd    <= ~sel_wr;
                  state     <= ISSUE;
               end
            end
            ISSUE: state <= WAIT;
            WAIT: begin
               if (slv_rsp) begin
                  ack       <= gnt ? 2'b10 : 2'b01;
                  rsp_rdata <= cmd_wr ? '0 : mem_rdata;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, round-robin, read/write, reset abort, timeout (if enabled).
module tb_mem_arbiter;
   localparam int AW = 4;
   localparam int DW = 32;

   logic            clk = 1'b0;
   logic            reset;
   logic [1:0]      req;
   logic [1:0]      req_wr;
   logic [2*AW-1:0] req_addr;
   logic [2*DW-1:0] req_wdata;
   logic [1:0]      ack;
   logic [1:0]      err;
   logic [DW-1:0]   rsp_rdata;
   logic            mem_wr;
   logic            mem_rd;
   logic [AW-1:0]   mem_addr;
   logic [DW-1:0]   mem_wdata;
   logic [DW-1:0]   mem_rdata;
   logic            slv_rsp;

   int total = 0;
   int bad   = 0;

   mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(15)) dut (
      .clk(clk), .reset(reset), .req(req), .req_wr(req_wr), .req_addr(req_addr),
      .req_wdata(req_wdata), .ack(ack), .err(err), .rsp_rdata(rsp_rdata),
      .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .slv_rsp(slv_rsp)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Caller drives req at a negedge; grant occurs on the following posedge.
   task automatic access(input string tag, input logic [1:0] exp_ack, input logic exp_wr,
                         input logic [3:0] exp_addr, input logic [31:0] exp_wdata,
                         input logic [31:0] rd, input int unsigned gap, input logic early);
      @(negedge clk);
      check({tag, ".rd"}, 64'(mem_rd), 64'(!exp_wr));
      check({tag, ".wr"}, 64'(mem_wr), 64'(exp_wr));
      check({tag, ".addr"}, 64'(mem_addr), 64'(exp_addr));
      if (exp_wr) check({tag, ".wdata"}, 64'(mem_wdata), 64'(exp_wdata));
      check({tag, ".ack_issue"}, 64'(ack), 64'(0));
      slv_rsp   = early;
      mem_rdata = 32'hBAD0_BAD0;
      for (int unsigned i = 0; i < gap; i++) begin
         @(negedge clk);
         slv_rsp = 1'b0;
         check({tag, ".ack_wait"}, 64'(ack), 64'(0));
         check({tag, ".strobe_wait"}, 64'({mem_wr, mem_rd}), 64'(0));
         check({tag, ".addr_hold"}, 64'(mem_addr), 64'(exp_addr));
      end
      @(negedge clk);
      check({tag, ".strobe_off"}, 64'({mem_wr, mem_rd}), 64'(0));
      slv_rsp   = 1'b1;
      mem_rdata = rd;
      @(negedge clk);
      slv_rsp = 1'b0;
      check({tag, ".ack"}, 64'(ack), 64'(exp_ack));
      check({tag, ".err"}, 64'(err), 64'(0));
      check({tag, ".rdata"}, 64'(rsp_rdata), exp_wr ? 64'(0) : 64'(rd));
      @(negedge clk);
      check({tag, ".ack_pulse"}, 64'(ack), 64'(0));
      check({tag, ".no_regrant"}, 64'({mem_wr, mem_rd}), 64'(0));
   endtask

   initial begin
      reset = 1'b0; req = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
      mem_rdata = '0; slv_rsp = 1'b0;
      repeat (2) @(negedge clk);
      check("rst.ack", 64'(ack), 64'(0));
      check("rst.err", 64'(err), 64'(0));
      check("rst.strobes", 64'({mem_wr, mem_rd}), 64'(0));
      check("rst.addr", 64'(mem_addr), 64'(0));
      check("rst.wdata", 64'(mem_wdata), 64'(0));
      check("rst.rdata", 64'(rsp_rdata), 64'(0));
      reset = 1'b1;
      @(negedge clk);

      // Both requesting from reset: grants alternate 0,1,0,1.
      req_addr = {4'h2, 4'h1};
      req_wr   = 2'b00;
      req      = 2'b11;
      access("sim0", 2'b01, 1'b0, 4'h1, 32'h0, 32'hA0A0_0001, 0, 1'b0);
      access("sim1", 2'b10, 1'b0, 4'h2, 32'h0, 32'hA0A0_0002, 0, 1'b0);
      access("sim2", 2'b01, 1'b0, 4'h1, 32'h0, 32'hA0A0_0003, 0, 1'b0);
      access("sim3", 2'b10, 1'b0, 4'h2, 32'h0, 32'hA0A0_0004, 0, 1'b0);
      req = 2'b00;

      req_addr[3:0] = 4'h3;
      req = 2'b01;
      access("rd0", 2'b01, 1'b0, 4'h3, 32'h0, 32'hDEAD_BEEF, 0, 1'b0);
      req = 2'b00;

      slv_rsp = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_rsp.ack", 64'(ack), 64'(0));
      check("idle_rsp.hold", 64'(rsp_rdata), 64'(32'hDEAD_BEEF));
      slv_rsp = 1'b0;

      // Write from requester 1, with a stray slv_rsp during ISSUE.
      req_wr            = 2'b10;
      req_addr[7:4]     = 4'hF;
      req_wdata[63:32]  = 32'h1234_5678;
      req = 2'b10;
      access("wr1", 2'b10, 1'b1, 4'hF, 32'h1234_5678, 32'hFFFF_0000, 1, 1'b1);
      req = 2'b00;
      req_wr = 2'b00;

      req_addr[3:0] = 4'h9;
      req = 2'b01;
      access("long0", 2'b01, 1'b0, 4'h9, 32'h0, 32'h5A5A_1234, 12, 1'b0);
      req = 2'b00;

`ifndef MEM_ARB_TIMEOUT_EN
      req = 2'b10;
      access("nowait1", 2'b10, 1'b0, 4'hF, 32'h0, 32'h0F0F_0F0F, 30, 1'b0);
      req = 2'b00;
      req_addr[3:0] = 4'h9;
      req = 2'b01;
      access("long0b", 2'b01, 1'b0, 4'h9, 32'h0, 32'h5A5A_1234, 3, 1'b0);
      req = 2'b00;
`endif

      // Abort mid-WAIT with requester 1 holding priority; reset must restore requester 0.
      req_addr[3:0] = 4'h5;
      req = 2'b01;
      @(negedge clk);
      check("rstw.issue", 64'(mem_rd), 64'(1));
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("rstw.addr", 64'(mem_addr), 64'(0));
      check("rstw.rdata", 64'(rsp_rdata), 64'(0));
      check("rstw.ack", 64'(ack), 64'(0));
      req = 2'b00;
      slv_rsp = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check("rstw.no_ack", 64'(ack), 64'(0));
      end
      slv_rsp = 1'b0;
      reset = 1'b1;
      req = 2'b11;
      access("post0", 2'b01, 1'b0, 4'h5, 32'h0, 32'h1111_2222, 0, 1'b0);
      req = 2'b10;
      access("post1", 2'b10, 1'b0, 4'hF, 32'h0, 32'h3333_4444, 0, 1'b0);
      req = 2'b00;

`ifdef MEM_ARB_TIMEOUT_EN
      req_addr[3:0] = 4'h6;
      req = 2'b01;
      @(negedge clk);
      check("to.issue", 64'(mem_rd), 64'(1));
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         check("to.wait_ack", 64'(ack), 64'(0));
      end
      @(negedge clk);
      check("to.ack", 64'(ack), 64'(2'b01));
      check("to.err", 64'(err), 64'(2'b01));
      check("to.rdata", 64'(rsp_rdata), 64'(0));
      req = 2'b00;
      @(negedge clk);
      check("to.pulse", 64'(ack), 64'(0));
      req = 2'b10;
      access("after_to", 2'b10, 1'b0, 4'hF, 32'h0, 32'h7777_8888, 0, 1'b0);
      req = 2'b00;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 4, memory address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, memory data width.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 15, maximum WAIT cycles before abort (used only with MEM_ARB_TIMEOUT_EN).
REQ-004 The block SHALL have one clock and an asynchronous active-low reset, with ports as listed below:
- clk  input  1  sole clock, all logic on posedge
- reset  input  1  asynchronous, active-low
- req  input  2  per-requester access request, bit i = requester i
- req_wr  input  2  bit i: 1 = write, 0 = read
- req_addr  input  2*ADDR_WIDTH  slice i = address of requester i
- req_wdata  input  2*DATA_WIDTH  slice i = write data of requester i
- ack  output  2  one-cycle completion pulse to requester i
- err  output  2  valid with ack; 1 = aborted access
- rsp_rdata  output  DATA_WIDTH  read data, valid in ack cycle
- mem_wr  output  1  memory write strobe
- mem_rd  output  1  memory read strobe
- mem_addr  output  ADDR_WIDTH  memory address
- mem_wdata  output  DATA_WIDTH  memory write data
- mem_rdata  input  DATA_WIDTH  memory read data
- slv_rsp  input  1  memory completion response

Function
REQ-005 The FSM SHALL have states IDLE, ISSUE and WAIT.
REQ-006 In IDLE with any req bit set, the block SHALL select one requester, register its wr/addr/wdata and move to ISSUE on the next edge.
REQ-007 Selection SHALL be round-robin: if both requests are set, the requester not granted last wins; after reset, requester 0 has priority.
REQ-008 In ISSUE, the block SHALL assert exactly one of mem_wr/mem_rd for exactly one cycle, with mem_addr/mem_wdata from the registered command, then enter WAIT.
REQ-009 mem_addr and mem_wdata SHALL hold the registered values from ISSUE through the end of WAIT; mem_wr and mem_rd SHALL be 0 outside ISSUE.
REQ-010 In WAIT, on the first cycle slv_rsp=1, the block SHALL register mem_rdata (reads) or 0 (writes) into rsp_rdata, pulse ack for the granted requester with err=0 in the next cycle, and return to IDLE.
REQ-011 Minimum latency SHALL be: req sampled at edge 0, strobe in cycle 1, slv_rsp in cycle 2, ack in cycle 3.
REQ-012 A new grant SHALL NOT be issued in the cycle ack is pulsed; IDLE re-arbitrates on the following edge.
REQ-013 Requesters SHALL hold req and command stable until ack; a req that drops before grant SHALL be ignored.
REQ-014 slv_rsp in IDLE or ISSUE SHALL be ignored.
REQ-015 At most one ack bit SHALL be set at any time.
REQ-016 rsp_rdata SHALL hold its value until the next ack.

Reset
REQ-017 When reset=0, the block SHALL, asynchronously, enter IDLE, clear ack, err, mem_wr, mem_rd, mem_addr, mem_wdata and rsp_rdata to 0, and set round-robin priority to requester 0.
REQ-018 Reset asserted mid-access SHALL abandon the access without generating an ack; operation SHALL resume on the first edge after reset deasserts.

Configuration
REQ-019 With MEM_ARB_TIMEOUT_EN defined, a counter SHALL count WAIT cycles; if slv_rsp is still 0 after TIMEOUT_CYCLES WAIT cycles, the block SHALL pulse ack with err=1 and rsp_rdata=0, then return to IDLE.
REQ-020 With MEM_ARB_TIMEOUT_EN defined, slv_rsp and the timeout in the same cycle SHALL resolve as a normal completion (err=0).
REQ-021 Without MEM_ARB_TIMEOUT_EN, the block SHALL wait in WAIT indefinitely, err SHALL be constant 0, and no counter SHALL be built.

Verification
REQ-022 Single read: req=01, req_wr=0, addr0=4'h3, slv_rsp one cycle after strobe with mem_rdata=32'hDEADBEEF -> mem_rd pulse with mem_addr=3, ack=01, rsp_rdata=DEADBEEF, err=0.
REQ-023 Simultaneous: req=11 held after reset -> grants alternate 0,1,0,1; no overlapping strobes; one ack per access.
REQ-024 Write: requester 1, addr=4'hF, wdata=32'h12345678 -> mem_wr one cycle, mem_addr=F, mem_wdata=12345678, ack=10.
REQ-025 Timeout (macro defined, TIMEOUT_CYCLES=15): slv_rsp never asserted -> ack with err=1 and rsp_rdata=0 after 15 WAIT cycles; a following request completes normally.
REQ-026 Reset mid-WAIT: reset=0 for 2 cycles during WAIT -> all outputs 0 immediately, no ack; next req=10 is granted to requester 1 only after requester 0 priority is restored (req=11 grants 0 first).
